// File: rtl/cw305_reg_batch.sv
// Batch-capable register front-end: runs BATCH back-to-back core operations from one GO write.
// Optional ciphertext XOR digest is built only when CW305_BATCH_DIGEST_EN is defined.
module cw305_reg_batch #(
    parameter int          pADDR_WIDTH    = 21,
    parameter int          pBYTECNT_SIZE  = 7,
    parameter int          pPT_WIDTH      = 128,
    parameter int          pCT_WIDTH      = 128,
    parameter int          pKEY_WIDTH     = 128,
    parameter int          pCNT_WIDTH     = 16,
    parameter int          pTIMEOUT_WIDTH = 16,
    parameter logic [7:0]  pIDENTIFY      = 8'h2f
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    output logic [7:0]                             read_data,
    input  logic [7:0]                             write_data,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic                                   reg_addrvalid,
    input  logic [pCT_WIDTH-1:0]                   I_cipherout,
    input  logic                                   I_done,
    output logic [pKEY_WIDTH-1:0]                  O_key,
    output logic [pPT_WIDTH-1:0]                   O_textin,
    output logic                                   O_start,
    output logic                                   O_busy
);

    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int W1 = (pPT_WIDTH > pCT_WIDTH) ? pPT_WIDTH : pCT_WIDTH;
    localparam int W2 = (W1 > pKEY_WIDTH) ? W1 : pKEY_WIDTH;
    localparam int W3 = (W2 > pCNT_WIDTH) ? W2 : pCNT_WIDTH;
    localparam int W4 = (W3 > pTIMEOUT_WIDTH) ? W3 : pTIMEOUT_WIDTH;
    localparam int RW = (W4 > 8) ? W4 : 8;

    localparam logic [AW-1:0] A_IDENT   = AW'(0);
    localparam logic [AW-1:0] A_TEXTIN  = AW'(1);
    localparam logic [AW-1:0] A_KEY     = AW'(2);
    localparam logic [AW-1:0] A_CTRL    = AW'(3);
    localparam logic [AW-1:0] A_STATUS  = AW'(4);
    localparam logic [AW-1:0] A_BATCH   = AW'(5);
    localparam logic [AW-1:0] A_DONECNT = AW'(6);
    localparam logic [AW-1:0] A_CIPHER  = AW'(7);
    localparam logic [AW-1:0] A_DIGEST  = AW'(8);
    localparam logic [AW-1:0] A_TIMEOUT = AW'(9);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE} state_t;

    state_t                     state;
    logic [pPT_WIDTH-1:0]       textin;
    logic [pKEY_WIDTH-1:0]      key;
    logic [pCNT_WIDTH-1:0]      batch;
    logic [pCNT_WIDTH-1:0]      donecnt;
    logic [pTIMEOUT_WIDTH-1:0]  timeout_cfg;
    logic [pTIMEOUT_WIDTH-1:0]  tmo_cnt;
    logic [pCT_WIDTH-1:0]       cipherout;
`ifdef CW305_BATCH_DIGEST_EN
    logic [pCT_WIDTH-1:0]       digest;
`endif
    logic                       inc_mode;
    logic                       timeout_flag;
    logic                       aborted_flag;
    logic                       done_r;
    logic                       start_q;
    logic                       busy_q;

    logic                       wr_en;
    logic                       ctrl_wr;
    logic                       go_wr;
    logic                       abort_wr;
    logic                       done_edge;
    logic [31:0]                byte_sh;
    logic [RW-1:0]              rd_word;
    logic [7:0]                 rd_byte;
    logic [pCNT_WIDTH-1:0]      donecnt_nxt;

    // Shifting past the register width drops the byte, so out-of-range bytes are ignored for free.
    function automatic logic [RW-1:0] byte_merge(input logic [RW-1:0] old,
                                                 input logic [7:0] data,
                                                 input logic [31:0] sh);
        byte_merge = (old & ~(RW'(8'hff) << sh)) | (RW'(data) << sh);
    endfunction

    assign wr_en       = reg_write & reg_addrvalid;
    assign ctrl_wr     = wr_en && (reg_address == A_CTRL) && (reg_bytecnt == '0);
    assign go_wr       = ctrl_wr & write_data[0];
    assign abort_wr    = ctrl_wr & write_data[1];
    assign done_edge   = I_done & ~done_r;
    assign byte_sh     = 32'(reg_bytecnt) << 3;
    assign donecnt_nxt = donecnt + pCNT_WIDTH'(1);

    always_comb begin
        rd_word = '0;
        case (reg_address)
            A_IDENT:   rd_word = RW'(pIDENTIFY);
            A_TEXTIN:  rd_word = RW'(textin);
            A_KEY:     rd_word = RW'(key);
            A_STATUS:  rd_word = RW'({aborted_flag, timeout_flag, busy_q});
            A_BATCH:   rd_word = RW'(batch);
            A_DONECNT: rd_word = RW'(donecnt);
            A_CIPHER:  rd_word = RW'(cipherout);
`ifdef CW305_BATCH_DIGEST_EN
            A_DIGEST:  rd_word = RW'(digest);
`endif
            A_TIMEOUT: rd_word = RW'(timeout_cfg);
            default:   rd_word = '0;
        endcase
        rd_byte = 8'(rd_word >> byte_sh);
    end

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state        <= S_IDLE;
            textin       <= '0;
            key          <= '0;
            batch        <= '0;
            donecnt      <= '0;
            timeout_cfg  <= '0;
            tmo_cnt      <= '0;
            cipherout    <= '0;
`ifdef CW305_BATCH_DIGEST_EN
            digest       <= '0;
`endif
            inc_mode     <= 1'b0;
            timeout_flag <= 1'b0;
            aborted_flag <= 1'b0;
            done_r       <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            read_data    <= '0;
        end else begin
            done_r    <= I_done;
            start_q   <= 1'b0;
            read_data <= (reg_read && reg_addrvalid) ? rd_byte : 8'h00;

            // Configuration is frozen while a batch runs.
            if (wr_en && !busy_q) begin
                case (reg_address)
                    A_TEXTIN:  textin      <= pPT_WIDTH'(byte_merge(RW'(textin), write_data, byte_sh));
                    A_KEY:     key         <= pKEY_WIDTH'(byte_merge(RW'(key), write_data, byte_sh));
                    A_BATCH:   batch       <= pCNT_WIDTH'(byte_merge(RW'(batch), write_data, byte_sh));
                    A_TIMEOUT: timeout_cfg <= pTIMEOUT_WIDTH'(byte_merge(RW'(timeout_cfg), write_data, byte_sh));
                    default: ;
                endcase
            end

            if (abort_wr && state != S_IDLE) begin
                state        <= S_IDLE;
                busy_q       <= 1'b0;
                aborted_flag <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go_wr) begin
                            donecnt      <= '0;
`ifdef CW305_BATCH_DIGEST_EN
                            digest       <= '0;
`endif
                            timeout_flag <= 1'b0;
                            aborted_flag <= 1'b0;
                            inc_mode     <= write_data[2];
                            if (batch != '0) begin
                                state   <= S_START;
                                start_q <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        tmo_cnt <= timeout_cfg;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        // Down-counter loaded with TIMEOUT expires on its last WAIT cycle.
                        if (done_edge) begin
                            cipherout <= I_cipherout;
                            state     <= S_CAPTURE;
                        end else if (timeout_cfg != '0 && tmo_cnt == pTIMEOUT_WIDTH'(1)) begin
                            timeout_flag <= 1'b1;
                            state        <= S_IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            tmo_cnt <= tmo_cnt - pTIMEOUT_WIDTH'(1);
                        end
                    end
                    S_CAPTURE: begin
`ifdef CW305_BATCH_DIGEST_EN
                        digest  <= digest ^ cipherout;
`endif
                        donecnt <= donecnt_nxt;
                        if (inc_mode) textin <= textin + pPT_WIDTH'(1);
                        if (donecnt_nxt == batch) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= S_START;
                            start_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_key    = key;
    assign O_textin = textin;
    assign O_start  = start_q;
    assign O_busy   = busy_q;

endmodule

// File: tb/tb_cw305_reg_batch.sv
// Scoreboard bench for cw305_reg_batch: a behavioural core answers each start pulse,
// expected plaintexts are queued at GO and popped at every observed start.
module tb_cw305_reg_batch;

    localparam logic [13:0] A_IDENT   = 14'h0;
    localparam logic [13:0] A_TEXTIN  = 14'h1;
    localparam logic [13:0] A_KEY     = 14'h2;
    localparam logic [13:0] A_CTRL    = 14'h3;
    localparam logic [13:0] A_STATUS  = 14'h4;
    localparam logic [13:0] A_BATCH   = 14'h5;
    localparam logic [13:0] A_DONECNT = 14'h6;
    localparam logic [13:0] A_CIPHER  = 14'h7;
    localparam logic [13:0] A_DIGEST  = 14'h8;
    localparam logic [13:0] A_TIMEOUT = 14'h9;
    localparam logic [13:0] A_UNUSED  = 14'h1a;

    logic         usb_clk;
    logic         reset_i;
    logic [13:0]  reg_address;
    logic [6:0]   reg_bytecnt;
    logic [7:0]   read_data;
    logic [7:0]   write_data;
    logic         reg_read;
    logic         reg_write;
    logic         reg_addrvalid;
    logic [127:0] I_cipherout;
    logic         I_done;
    logic [127:0] O_key;
    logic [127:0] O_textin;
    logic         O_start;
    logic         O_busy;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           n_start = 0;
    int           lat = 0;
    int           core_lat = 10;
    bit           core_en = 1'b1;
    bit           hold = 1'b0;
    logic [127:0] acc = '0;
    logic [127:0] last_ct = '0;
    logic [127:0] exp_q[$];

    cw305_reg_batch dut (
        .usb_clk       (usb_clk),
        .reset_i       (reset_i),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .read_data     (read_data),
        .write_data    (write_data),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .I_cipherout   (I_cipherout),
        .I_done        (I_done),
        .O_key         (O_key),
        .O_textin      (O_textin),
        .O_start       (O_start),
        .O_busy        (O_busy)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;
    always @(posedge usb_clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural core: done rises core_lat cycles after the start cycle.
    always @(negedge usb_clk) begin
        bit fire;
        fire = 1'b0;
        if (reset_i) begin
            lat    = 0;
            I_done = 1'b0;
        end else begin
            if (O_start) begin
                n_start = n_start + 1;
                if (exp_q.size() == 0) chk("start_unexpected", 128'd1, 128'd0);
                else chk("textin_at_start", O_textin, exp_q.pop_front());
                lat = core_lat;
            end else if (lat > 0) begin
                lat  = lat - 1;
                fire = (lat == 0) && core_en;
            end
            if (fire) begin
                last_ct     = {$urandom, $urandom, $urandom, $urandom};
                I_cipherout = last_ct;
                acc         = acc ^ last_ct;
            end
            I_done = hold ? ((lat == 0) || (lat > core_lat - 2)) : fire;
        end
    end

    task automatic wr_byte(input logic [13:0] a, input int k, input logic [7:0] d);
        @(posedge usb_clk); #1;
        reg_address = a; reg_bytecnt = 7'(k); write_data = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        @(posedge usb_clk); #1;
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic wr_reg(input logic [13:0] a, input int n, input logic [127:0] v);
        for (int k = 0; k < n; k++) wr_byte(a, k, 8'(v >> (8 * k)));
    endtask

    task automatic rd_byte(input logic [13:0] a, input int k, output logic [7:0] b);
        @(posedge usb_clk); #1;
        reg_address = a; reg_bytecnt = 7'(k);
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        @(posedge usb_clk); #1;
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        b = read_data;
    endtask

    task automatic rd_reg(input logic [13:0] a, input int n, output logic [127:0] v);
        logic [7:0] b;
        v = '0;
        for (int k = 0; k < n; k++) begin
            rd_byte(a, k, b);
            v = v | (128'(b) << (8 * k));
        end
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge usb_clk);
            if (!O_busy) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("busy_stuck", 128'd1, 128'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           s0, g, c;
        logic [127:0] v, base, exp_dig;
        logic [7:0]   b;
        logic [127:0] k1, t2;

        reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; write_data = '0;
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
        I_cipherout = '0; I_done = 1'b0;
        repeat (3) @(posedge usb_clk);
        #1 reset_i = 1'b0;

        chk("rst_busy", 128'(O_busy), 128'd0);
        chk("rst_start", 128'(O_start), 128'd0);
        chk("rst_key", O_key, 128'd0);
        chk("rst_textin", O_textin, 128'd0);
        chk("rst_rdata", 128'(read_data), 128'd0);
        rd_reg(A_IDENT, 1, v);  chk("identify", v, 128'h2f);
        rd_reg(A_STATUS, 1, v); chk("status_rst", v, 128'd0);
        idle_cycles(1);
        chk("rdata_no_read", 128'(read_data), 128'd0);

        // register map boundaries
        wr_reg(A_BATCH, 3, 128'hAA_1234);
        rd_reg(A_BATCH, 2, v);     chk("batch_rdback", v, 128'h1234);
        rd_byte(A_BATCH, 2, b);    chk("batch_byte2", 128'(b), 128'd0);
        k1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        wr_reg(A_KEY, 16, k1);
        chk("key_write", O_key, k1);
        rd_reg(A_KEY, 16, v);      chk("key_rdback", v, k1);
        rd_byte(A_UNUSED, 0, b);   chk("unmapped_addr", 128'(b), 128'd0);

        // single op, latency 10
        core_lat = 10;
        wr_reg(A_TEXTIN, 16, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        wr_reg(A_BATCH, 2, 128'd1);
        s0 = n_start;
        exp_q.push_back(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        wr_byte(A_CTRL, 0, 8'h01);
        g = cyc;
        chk("t1_start_pulse", 128'(O_start), 128'd1);
        wait_idle(c);
        chk("t1_starts", 128'(n_start - s0), 128'd1);
        chk("t1_latency", 128'(c - g), 128'd12);
        rd_reg(A_DONECNT, 2, v);   chk("t1_donecnt", v, 128'd1);
        rd_reg(A_CIPHER, 16, v);   chk("t1_cipher", v, last_ct);
        rd_reg(A_STATUS, 1, v);    chk("t1_status", v, 128'd0);

        // batch of 4 with increment across the wrap
        t2 = {128{1'b1}} - 128'd1;
        wr_reg(A_TEXTIN, 16, t2);
        wr_reg(A_BATCH, 2, 128'd4);
        for (int i = 0; i < 4; i++) exp_q.push_back(t2 + 128'(i));
        s0 = n_start;
        base = acc;
        wr_byte(A_CTRL, 0, 8'h05);
        g = cyc;
        wait_idle(c);
        chk("t2_starts", 128'(n_start - s0), 128'd4);
        chk("t2_latency", 128'(c - g), 128'd48);
        chk("t2_o_textin", O_textin, 128'd2);
        rd_reg(A_TEXTIN, 16, v);   chk("t2_textin_rd", v, 128'd2);
        rd_reg(A_DONECNT, 2, v);   chk("t2_donecnt", v, 128'd4);
        rd_reg(A_CIPHER, 16, v);   chk("t2_cipher", v, last_ct);
`ifdef CW305_BATCH_DIGEST_EN
        exp_dig = acc ^ base;
`else
        exp_dig = '0;
`endif
        rd_reg(A_DIGEST, 16, v);   chk("t2_digest", v, exp_dig);

        // timeout with a silent core
        core_en = 1'b0;
        wr_reg(A_TIMEOUT, 2, 128'd5);
        wr_reg(A_BATCH, 2, 128'd1);
        exp_q.push_back(128'd2);
        s0 = n_start;
        wr_byte(A_CTRL, 0, 8'h01);
        g = cyc;
        wait_idle(c);
        chk("t3_latency", 128'(c - g), 128'd6);
        idle_cycles(8);
        chk("t3_starts", 128'(n_start - s0), 128'd1);
        rd_reg(A_STATUS, 1, v);    chk("t3_status", v, 128'b010);
        rd_reg(A_DONECNT, 2, v);   chk("t3_donecnt", v, 128'd0);
        core_en = 1'b1;
        wr_reg(A_TIMEOUT, 2, 128'd0);

        // abort (with GO in the same write) after three completions
        core_lat = 3;
        wr_reg(A_TEXTIN, 16, 128'h55);
        wr_reg(A_BATCH, 2, 128'd100);
        for (int i = 0; i < 4; i++) exp_q.push_back(128'h55);
        s0 = n_start;
        wr_byte(A_CTRL, 0, 8'h01);
        for (int k = 0; k < 500 && (n_start - s0) < 4; k++) @(negedge usb_clk);
        chk("t4_reached_4th", 128'(n_start - s0), 128'd4);
        chk("t4_busy_before", 128'(O_busy), 128'd1);
        wr_byte(A_CTRL, 0, 8'h03);
        chk("t4_busy_after", 128'(O_busy), 128'd0);
        idle_cycles(10);
        chk("t4_starts", 128'(n_start - s0), 128'd4);
        rd_reg(A_STATUS, 1, v);    chk("t4_status", v, 128'b100);
        rd_reg(A_DONECNT, 2, v);   chk("t4_donecnt", v, 128'd3);

        // BATCH=0 does nothing
        wr_reg(A_BATCH, 2, 128'd0);
        s0 = n_start;
        wr_byte(A_CTRL, 0, 8'h01);
        chk("t5_busy", 128'(O_busy), 128'd0);
        idle_cycles(8);
        chk("t5_starts", 128'(n_start - s0), 128'd0);
        chk("t5_busy_late", 128'(O_busy), 128'd0);

        // done level held across operations
        core_lat = 10;
        hold = 1'b1;
        wr_reg(A_TEXTIN, 16, 128'h77);
        wr_reg(A_BATCH, 2, 128'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back(128'h77);
        s0 = n_start;
        wr_byte(A_CTRL, 0, 8'h01);
        g = cyc;
        wait_idle(c);
        chk("t6_starts", 128'(n_start - s0), 128'd3);
        chk("t6_latency", 128'(c - g), 128'd36);
        rd_reg(A_DONECNT, 2, v);   chk("t6_donecnt", v, 128'd3);
        hold = 1'b0;
        idle_cycles(2);

        // writes ignored while busy, then reset mid-WAIT
        wr_reg(A_TEXTIN, 16, 128'h99);
        wr_reg(A_BATCH, 2, 128'd5);
        exp_q.push_back(128'h99);
        s0 = n_start;
        wr_byte(A_CTRL, 0, 8'h01);
        wr_byte(A_KEY, 0, 8'h5a);
        wr_byte(A_TEXTIN, 0, 8'h11);
        chk("t7_key_locked", O_key, k1);
        chk("t7_textin_locked", O_textin, 128'h99);
        chk("t7_busy_mid", 128'(O_busy), 128'd1);
        @(posedge usb_clk); #1 reset_i = 1'b1;
        @(posedge usb_clk); #1 reset_i = 1'b0;
        chk("t7_rst_busy", 128'(O_busy), 128'd0);
        chk("t7_rst_start", 128'(O_start), 128'd0);
        chk("t7_rst_key", O_key, 128'd0);
        chk("t7_rst_textin", O_textin, 128'd0);
        chk("t7_rst_rdata", 128'(read_data), 128'd0);
        idle_cycles(20);
        chk("t7_starts", 128'(n_start - s0), 128'd1);
        rd_reg(A_DONECNT, 2, v);   chk("t7_donecnt", v, 128'd0);

        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
